// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the RV32I decode stage.
interface instr_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [10:0]     out_class;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_class, out_rd,
        output out_rs1, out_rs2, out_funct3, out_funct7b5,
        output out_imm, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_class, out_rd,
        input  out_rs1, out_rs2, out_funct3, out_funct7b5,
        input  out_imm, out_illegal
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage: classify, extract fields, build immediate,
// with an optional skid register so both handshake directions are flops.
module instr_decode_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input logic clk,
    input logic rst,
    input logic flush,
    instr_decode_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [10:0]     cls;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundleT;

    typedef enum logic [1:0] {
        OUT_EMPTY,
        OUT_FULL,
        BOTH_FULL
    } stateT;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [10:0] rawCls;
    logic [10:0] cls;
    logic        legal;
    logic [31:0] imm32;
    logic        sgnImm;
    bundleT      dec;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        rawCls     = '0;
        rawCls[0]  = opcode == 7'b0110011;
        rawCls[1]  = opcode == 7'b0010011;
        rawCls[2]  = opcode == 7'b1100111;
        rawCls[3]  = opcode == 7'b0000011;
        rawCls[4]  = opcode == 7'b0100011;
        rawCls[5]  = opcode == 7'b1100011;
        rawCls[6]  = opcode == 7'b0010111;
        rawCls[7]  = opcode == 7'b0110111;
        rawCls[8]  = opcode == 7'b1101111;
        rawCls[9]  = opcode == 7'b1110011;
        rawCls[10] = opcode == 7'b0001111;
    end

    // Unknown opcodes fall to default with rawCls all zero.
    always_comb begin
        legal = 1'b0;
        unique case (1'b1)
            rawCls[0]: legal = (funct7 == 7'h00) ||
                               (funct7 == 7'h20 &&
                                (funct3 == 3'b000 || funct3 == 3'b101));
            rawCls[1]: begin
                if (funct3 == 3'b001)
                    legal = funct7 == 7'h00;
                else if (funct3 == 3'b101)
                    legal = funct7 == 7'h00 || funct7 == 7'h20;
                else
                    legal = 1'b1;
            end
            rawCls[2]: legal = funct3 == 3'b000;
            rawCls[3]: legal = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
            rawCls[4]: legal = funct3 < 3'b011;
            rawCls[5]: legal = funct3[2:1] != 2'b01;
            default:   legal = |rawCls;
        endcase
    end

    assign cls = legal ? rawCls : '0;

    always_comb begin
        imm32  = '0;
        sgnImm = 1'b1;
        unique case (1'b1)
            cls[1], cls[2], cls[3]:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            cls[4]:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            cls[5]:
                imm32 = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            cls[6], cls[7]:
                imm32 = {instr[31:12], 12'b0};
            cls[8]:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
            cls[9]: begin
                imm32  = {20'b0, instr[31:20]};
                sgnImm = 1'b0;
            end
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.pc       = bus.in_pc;
        dec.cls      = cls;
        dec.rd       = (cls[4] | cls[5] | cls[10] | !legal) ? 5'd0 : instr[11:7];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        dec.funct3   = funct3;
        dec.funct7b5 = instr[30];
        dec.imm      = sgnImm ? XLEN'($signed(imm32)) : XLEN'(imm32);
        dec.illegal  = !legal;
    end

    stateT  state;
    stateT  nextState;
    bundleT outQ;
    bundleT skidQ;
    logic   readyQ;
    logic   outValid;
    logic   accept;
    logic   drain;
    logic   loadOut;
    logic   loadSkid;
    logic   outFromSkid;

    assign outValid = state != OUT_EMPTY;
    assign accept   = bus.in_valid && bus.in_ready;
    assign drain    = outValid && bus.out_ready;

    always_comb begin
        nextState   = state;
        loadOut     = 1'b0;
        loadSkid    = 1'b0;
        outFromSkid = 1'b0;
        unique case (state)
            OUT_EMPTY: begin
                if (accept) begin
                    loadOut   = 1'b1;
                    nextState = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (accept && drain) begin
                    loadOut = 1'b1;
                end else if (accept) begin
                    loadSkid  = 1'b1;
                    nextState = BOTH_FULL;
                end else if (drain) begin
                    nextState = OUT_EMPTY;
                end
            end
            BOTH_FULL: begin
                if (drain) begin
                    outFromSkid = 1'b1;
                    nextState   = OUT_FULL;
                end
            end
            default: nextState = OUT_EMPTY;
        endcase
        // A redirect kills everything held and anything arriving this cycle.
        if (flush) begin
            nextState   = OUT_EMPTY;
            loadOut     = 1'b0;
            loadSkid    = 1'b0;
            outFromSkid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= OUT_EMPTY;
            readyQ <= 1'b1;
            outQ   <= '0;
            skidQ  <= '0;
        end else begin
            state  <= nextState;
            readyQ <= nextState != BOTH_FULL;
            if (loadOut)
                outQ <= dec;
            else if (outFromSkid)
                outQ <= skidQ;
            if (loadSkid)
                skidQ <= dec;
        end
    end

    assign bus.in_ready = !rst &&
                          (SKID ? readyQ : (!outValid || bus.out_ready));

    assign bus.out_valid    = outValid;
    assign bus.out_pc       = outQ.pc;
    assign bus.out_class    = outQ.cls;
    assign bus.out_rd       = outQ.rd;
    assign bus.out_rs1      = outQ.rs1;
    assign bus.out_rs2      = outQ.rs2;
    assign bus.out_funct3   = outQ.funct3;
    assign bus.out_funct7b5 = outQ.funct7b5;
    assign bus.out_imm      = outQ.imm;
    assign bus.out_illegal  = outQ.illegal;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode table, stream, stall,
// flush and reset sequences on a SKID=1 and a SKID=0 instance.
module tb_instr_decode_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        tbValid;
    logic        tbReady;
    logic [31:0] tbInstr;
    logic [31:0] tbPc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_decode_stage_if #(.XLEN(32)) bus1 ();
    instr_decode_stage_if #(.XLEN(32)) bus0 ();

    assign bus1.in_valid  = tbValid;
    assign bus1.in_instr  = tbInstr;
    assign bus1.in_pc     = tbPc;
    assign bus1.out_ready = tbReady;
    assign bus0.in_valid  = tbValid;
    assign bus0.in_instr  = tbInstr;
    assign bus0.in_pc     = tbPc;
    assign bus0.out_ready = tbReady;

    instr_decode_stage #(.XLEN(32), .SKID(1'b1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus1)
    );

    instr_decode_stage #(.XLEN(32), .SKID(1'b0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus0)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [10:0] cls;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ill;
    } vecT;

    vecT vecs[19];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(string tag, vecT e);
        check({tag, ".s1.valid"}, 32'(bus1.out_valid), 32'd1);
        check({tag, ".s1.pc"}, bus1.out_pc, e.pc);
        check({tag, ".s1.class"}, 32'(bus1.out_class), 32'(e.cls));
        check({tag, ".s1.rd"}, 32'(bus1.out_rd), 32'(e.rd));
        check({tag, ".s1.imm"}, bus1.out_imm, e.imm);
        check({tag, ".s1.illegal"}, 32'(bus1.out_illegal), 32'(e.ill));
    endtask

    task automatic chk0(string tag, vecT e);
        check({tag, ".s0.valid"}, 32'(bus0.out_valid), 32'd1);
        check({tag, ".s0.pc"}, bus0.out_pc, e.pc);
        check({tag, ".s0.class"}, 32'(bus0.out_class), 32'(e.cls));
        check({tag, ".s0.rd"}, 32'(bus0.out_rd), 32'(e.rd));
        check({tag, ".s0.imm"}, bus0.out_imm, e.imm);
        check({tag, ".s0.illegal"}, 32'(bus0.out_illegal), 32'(e.ill));
    endtask

    task automatic drive(vecT e);
        tbInstr = e.instr;
        tbPc    = e.pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkReady0(string tag);
        check({tag, ".s0.inReadyComb"}, 32'(bus0.in_ready),
              32'(!bus0.out_valid || tbReady));
    endtask

    task automatic chkResetState(string tag);
        check({tag, ".s1.valid"}, 32'(bus1.out_valid), 32'd0);
        check({tag, ".s1.inReady"}, 32'(bus1.in_ready), 32'd0);
        check({tag, ".s1.pc"}, bus1.out_pc, 32'd0);
        check({tag, ".s1.imm"}, bus1.out_imm, 32'd0);
        check({tag, ".s1.class"}, 32'(bus1.out_class), 32'd0);
        check({tag, ".s1.rd"}, 32'(bus1.out_rd), 32'd0);
        check({tag, ".s1.illegal"}, 32'(bus1.out_illegal), 32'd0);
        check({tag, ".s0.valid"}, 32'(bus0.out_valid), 32'd0);
        check({tag, ".s0.inReady"}, 32'(bus0.in_ready), 32'd0);
        check({tag, ".s0.pc"}, bus0.out_pc, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h003100B3, 32'h100, 11'h001, 5'd1, 32'h0, 1'b0};
        vecs[1]  = '{32'hFFF10093, 32'h104, 11'h002, 5'd1, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{32'h001000EF, 32'h108, 11'h100, 5'd1, 32'h00000800, 1'b0};
        vecs[3]  = '{32'hFE512E23, 32'h10C, 11'h010, 5'd0, 32'hFFFFFFFC, 1'b0};
        vecs[4]  = '{32'hFE000FE3, 32'h110, 11'h020, 5'd0, 32'hFFFFFFFE, 1'b0};
        vecs[5]  = '{32'h123450B7, 32'h114, 11'h080, 5'd1, 32'h12345000, 1'b0};
        vecs[6]  = '{32'h300110F3, 32'h118, 11'h200, 5'd1, 32'h00000300, 1'b0};
        vecs[7]  = '{32'h00001297, 32'h11C, 11'h040, 5'd5, 32'h00001000, 1'b0};
        vecs[8]  = '{32'hFF80A183, 32'h120, 11'h008, 5'd3, 32'hFFFFFFF8, 1'b0};
        vecs[9]  = '{32'h000280E7, 32'h124, 11'h004, 5'd1, 32'h0, 1'b0};
        vecs[10] = '{32'h0FF0008F, 32'h128, 11'h400, 5'd0, 32'h0, 1'b0};
        vecs[11] = '{32'h40315093, 32'h12C, 11'h002, 5'd1, 32'h00000403, 1'b0};
        vecs[12] = '{32'h403110B3, 32'h130, 11'h000, 5'd0, 32'h0, 1'b1};
        vecs[13] = '{32'hFF80F183, 32'h134, 11'h000, 5'd0, 32'h0, 1'b1};
        vecs[14] = '{32'h00000000, 32'h138, 11'h000, 5'd0, 32'h0, 1'b1};
        vecs[15] = '{32'hFFFFFFFF, 32'h13C, 11'h000, 5'd0, 32'h0, 1'b1};
        vecs[16] = '{32'h40311093, 32'h140, 11'h000, 5'd0, 32'h0, 1'b1};
        vecs[17] = '{32'h000290E7, 32'h144, 11'h000, 5'd0, 32'h0, 1'b1};
        vecs[18] = '{32'hFE002FE3, 32'h148, 11'h000, 5'd0, 32'h0, 1'b1};

        rst     = 1'b1;
        flush   = 1'b0;
        tbValid = 1'b0;
        tbReady = 1'b1;
        tbInstr = '0;
        tbPc    = '0;
        step();
        step();
        chkResetState("reset");
        rst = 1'b0;
        #1;
        check("reset.s1.inReadyAfter", 32'(bus1.in_ready), 32'd1);
        check("reset.s0.inReadyAfter", 32'(bus0.in_ready), 32'd1);

        // Decode table, one instruction at a time
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            tbValid = 1'b1;
            step();
            tbValid = 1'b0;
            chk1($sformatf("vec%0d", i), vecs[i]);
            chk0($sformatf("vec%0d", i), vecs[i]);
            step();
            check($sformatf("vec%0d.s1.drained", i),
                  32'(bus1.out_valid), 32'd0);
        end

        // Back-to-back stream
        tbReady = 1'b1;
        tbValid = 1'b1;
        drive(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) drive(vecs[i + 1]);
            else tbValid = 1'b0;
            chk1($sformatf("stream%0d", i), vecs[i]);
            chk0($sformatf("stream%0d", i), vecs[i]);
            chkReady0($sformatf("stream%0d", i));
        end
        step();
        check("stream.s1.end", 32'(bus1.out_valid), 32'd0);
        check("stream.s0.end", 32'(bus0.out_valid), 32'd0);

        // Stall with skid fill: A, B, C
        tbReady = 1'b0;
        tbValid = 1'b1;
        drive(vecs[0]);
        step();
        chk1("stallA", vecs[0]);
        check("stallA.s1.inReady", 32'(bus1.in_ready), 32'd1);
        chk0("stallA", vecs[0]);
        chkReady0("stallA");
        drive(vecs[1]);
        step();
        chk1("stallB", vecs[0]);
        check("stallB.s1.inReady", 32'(bus1.in_ready), 32'd0);
        chkReady0("stallB");
        drive(vecs[2]);
        step();
        chk1("stallC", vecs[0]);
        check("stallC.s1.inReady", 32'(bus1.in_ready), 32'd0);
        tbReady = 1'b1;
        #1;
        chkReady0("release");
        step();
        chk1("drainB", vecs[1]);
        check("drainB.s1.inReady", 32'(bus1.in_ready), 32'd1);
        step();
        tbValid = 1'b0;
        chk1("drainC", vecs[2]);
        step();
        check("drainEnd.s1.valid", 32'(bus1.out_valid), 32'd0);
        step();

        // Flush while both entries full and input valid
        tbReady = 1'b0;
        tbValid = 1'b1;
        drive(vecs[3]);
        step();
        drive(vecs[4]);
        step();
        check("flushPre.s1.inReady", 32'(bus1.in_ready), 32'd0);
        flush = 1'b1;
        drive(vecs[5]);
        step();
        flush   = 1'b0;
        tbValid = 1'b0;
        check("flush.s1.valid", 32'(bus1.out_valid), 32'd0);
        check("flush.s1.inReady", 32'(bus1.in_ready), 32'd1);
        check("flush.s0.valid", 32'(bus0.out_valid), 32'd0);
        check("flush.s0.inReady", 32'(bus0.in_ready), 32'd1);
        tbReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("flushQuiet%0d.s1", i),
                  32'(bus1.out_valid), 32'd0);
            check($sformatf("flushQuiet%0d.s0", i),
                  32'(bus0.out_valid), 32'd0);
        end

        // Flush beats a simultaneous accept into an empty-able stage
        tbReady = 1'b0;
        tbValid = 1'b1;
        drive(vecs[6]);
        step();
        chk1("flush2Pre", vecs[6]);
        flush = 1'b1;
        drive(vecs[7]);
        step();
        flush   = 1'b0;
        tbValid = 1'b0;
        check("flush2.s1.valid", 32'(bus1.out_valid), 32'd0);
        check("flush2.s0.valid", 32'(bus0.out_valid), 32'd0);
        step();
        check("flush2Quiet.s1", 32'(bus1.out_valid), 32'd0);

        // Reset mid-stall
        tbReady = 1'b0;
        tbValid = 1'b1;
        drive(vecs[1]);
        step();
        drive(vecs[2]);
        step();
        rst = 1'b1;
        step();
        tbValid = 1'b0;
        chkResetState("midReset");
        rst     = 1'b0;
        tbReady = 1'b1;
        #1;
        check("midReset.s1.inReadyAfter", 32'(bus1.in_ready), 32'd1);
        check("midReset.s0.inReadyAfter", 32'(bus0.in_ready), 32'd1);
        step();
        check("midReset.s1.quiet", 32'(bus1.out_valid), 32'd0);
        check("midReset.s1.inReadyHold", 32'(bus1.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered RV32I instruction decode stage between fetch and register-read/execute in Ripple-32. It accepts one 32-bit instruction plus its PC per valid/ready handshake. It classifies the instruction across the complete RV32I base opcode map, extracts register fields, builds the sign-extended immediate and flags illegal encodings. The decoded bundle is presented one cycle later, behind an optional skid buffer that lets both handshake directions be registered.

## Interface
- XLEN, 32: width of `in_pc`, `out_pc` and `out_imm`; must be ≥ 32, with immediates sign-extended to XLEN.
- SKID, 1: 1 = two-entry stage (output register plus skid register), `in_ready` is registered; 0 = single output register, `in_ready` is combinational.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held instructions (redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of `in_instr`.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  XLEN  PC of bundle.
- out_class  out  11  one-hot: [0] ALUreg, [1] ALUimm, [2] JALR, [3] Load, [4] Store, [5] Branch, [6] AUIPC, [7] LUI, [8] JAL, [9] SYSTEM, [10] FENCE.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_funct3  out  3  instr[14:12].
- out_funct7b5  out  1  instr[30].
- out_imm  out  XLEN  decoded immediate.
- out_illegal  out  1  illegal encoding; `out_class` is all zero when set.

## Operation
- Opcodes: ALUreg 0110011, ALUimm 0010011, JALR 1100111, Load 0000011, Store 0100011, Branch 1100011, AUIPC 0010111, LUI 0110111, JAL 1101111, SYSTEM 1110011, FENCE 0001111.
- Illegal when any of the following holds:
  - opcode not in the list above, including `instr[1:0] != 11`;
  - ALUreg with funct7 ∉ {0x00, 0x20}, or funct7 = 0x20 with funct3 ∉ {000, 101};
  - ALUimm shift (funct3 001/101) with instr[31:25] ∉ {0x00, 0x20 (funct3 101 only)};
  - JALR with funct3 ≠ 000;
  - Load with funct3 ∈ {011, 110, 111};
  - Store with funct3 ≥ 011;
  - Branch with funct3 ∈ {010, 011}.
- Illegal instructions still flow through with `out_illegal=1`; trapping is downstream's job.
- Immediate by class:
  - I (ALUimm, JALR, Load): sext instr[31:20].
  - S: sext {instr[31:25], instr[11:7]}.
  - B: sext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sext.
  - J: sext {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - SYSTEM: zero-extended instr[31:20] (CSR address).
  - ALUreg, FENCE, illegal: 0.
- `out_rd` is forced to 0 for Store, Branch, FENCE and illegal. `out_rs1`, `out_rs2`, `out_funct3` and `out_funct7b5` are raw fields in all cases.
- SKID=1 state: OUT_EMPTY → OUT_FULL → BOTH_FULL.
  - Accept into the output register when it is empty or draining.
  - Accept into the skid register when `out_valid && !out_ready`.
  - On drain with skid full, the skid entry moves to output; order is preserved.
- SKID=0: `in_ready = !out_valid || out_ready`.

## Timing
- Latency: accept at edge N → bundle visible with `out_valid=1` after edge N, i.e. one cycle.
- Throughput: one instruction per cycle while `out_ready=1`, in both modes.
- SKID=1: `in_ready` is a flop, equal to "skid empty".
  - Accepting while the output stalls fills skid; `in_ready` falls next cycle.
  - A drain with skid full empties skid; `in_ready` rises next cycle.
  - No instruction is lost or duplicated.
- Bundle stability: while `out_valid && !out_ready`, every output holds stable.
- Reset: `out_valid=0`, skid empty, all data outputs 0, `out_illegal=0`; `in_ready=0` during rst, 1 the first cycle after.
- flush:
  - Clears output and skid valids at that edge.
  - Takes priority over a simultaneous accept; the input that cycle is dropped.
  - Takes priority over a simultaneous output handshake; downstream must ignore it.
  - `in_ready=1` the next cycle.
- rst asserted mid-stall discards all held instructions identically.

## Test plan
- Back-to-back stream with `out_ready=1`: ADD 0x003100B3, ADDI x1,x2,-1 0xFFF10093, JAL x1,+2048 0x001000EF, each accepted in consecutive cycles → outputs one cycle later, in order. Expected: class ALUreg; then ALUimm with imm 0xFFFFFFFF; then JAL with imm 0x00000800 and rd=1.
- Immediate formats: SW x5,-4(x2) 0xFE512E23 → imm 0xFFFFFFFC, rd=0. BEQ with offset −2 (0xFE000FE3) → imm 0xFFFFFFFE. LUI 0x12345 → imm 0x12345000. CSRRW on 0x300 → imm 0x00000300.
- Illegal encodings, each → `out_illegal=1`, class 0, rd 0: SUB with funct3 001; Load with funct3 111; opcode 0000000; 0xFFFFFFFF.
- Stall (SKID=1): hold `out_ready=0` while sending A, B, C.
  - Required: A at output, B in skid, `in_ready=0`; C is not accepted.
  - Release `out_ready` → A, B, C emerge in order, with `in_ready` back at 1 one cycle after the skid drains.
- Flush while both entries are full, concurrent with `in_valid`: next cycle `out_valid=0` and `in_ready=1`, and no stale bundle ever appears.
- Reset mid-stall: all outputs 0 during rst. Repeat the first scenario with SKID=0, and check `in_ready` follows `!out_valid || out_ready` combinationally.
